// File: rtl/soc_system_sensors_input_if.sv
// rtl/soc_system_sensors_input_if.sv - Avalon-MM register bus for the sensor input port
interface soc_system_sensors_input_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/soc_system_sensors_input.sv
// rtl/soc_system_sensors_input.sv - synchronized, debounced sensor inputs with W1C edge capture and irq
module soc_system_sensors_input #(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    soc_system_sensors_input_if.slave    bus,
    input  logic [WIDTH-1:0]             in_port,
    output logic                         irq
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] clr_mask;
    logic [CW-1:0]    cnt [WIDTH];
    logic             wr_en;

    // accept: the differing level has persisted long enough to become the new stable value
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
        end
    end

    always_comb begin
        edge_set = accept;
        if (EDGE_TYPE == 0) begin
            edge_set = accept & sync2;
        end else if (EDGE_TYPE == 1) begin
            edge_set = accept & ~sync2;
        end
    end

    assign wr_en    = bus.chipselect & ~bus.write_n;
    assign clr_mask = (wr_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // a fresh capture wins over a W1C of the same bit on the same edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask    <= '0;
            edgecapture <= '0;
        end else begin
            if (wr_en && bus.address == 2'd2) begin
                irq_mask <= bus.writedata[WIDTH-1:0];
            end
            edgecapture <= (edgecapture & ~clr_mask) | edge_set;
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0:    bus.readdata[WIDTH-1:0] = stable;
            2'd2:    bus.readdata[WIDTH-1:0] = irq_mask;
            2'd3:    bus.readdata[WIDTH-1:0] = edgecapture;
            default: bus.readdata = '0;
        endcase
    end

    assign irq = |(edgecapture & irq_mask);

    generate
        if (WIDTH < 32) begin : g_unused
            logic unused_hi;
            assign unused_hi = ^bus.writedata[31:WIDTH];
        end
    endgenerate
endmodule

// File: tb/tb_soc_system_sensors_input.sv
// tb/tb_soc_system_sensors_input.sv - randomized self-checking bench against a sliding-window model
module tb_soc_system_sensors_input;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  in_port = '0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic        irq_a;
    logic        irq_r;

    always #10 clk = ~clk;

    soc_system_sensors_input_if bus_a ();
    soc_system_sensors_input_if bus_r ();

    assign bus_a.address    = address;
    assign bus_a.chipselect = chipselect;
    assign bus_a.write_n    = write_n;
    assign bus_a.writedata  = writedata;
    assign bus_r.address    = address;
    assign bus_r.chipselect = chipselect;
    assign bus_r.write_n    = write_n;
    assign bus_r.writedata  = writedata;

    soc_system_sensors_input #(.WIDTH(3), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a), .in_port(in_port), .irq(irq_a)
    );

    soc_system_sensors_input #(.WIDTH(3), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) dut_r (
        .clk(clk), .reset_n(reset_n), .bus(bus_r), .in_port(in_port), .irq(irq_r)
    );

    // model: hist[j] is in_port sampled j+1 edges before the edge being evaluated
    logic [2:0] hist [D+1];
    logic [2:0] m_stable;
    logic [2:0] m_mask;
    logic [2:0] m_ecap_a;
    logic [2:0] m_ecap_r;
    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int j = 0; j <= D; j++) hist[j] = '0;
        m_stable = '0;
        m_mask   = '0;
        m_ecap_a = '0;
        m_ecap_r = '0;
    endtask

    // a bit flips once the last D synchronized samples all disagree with its stable value
    task automatic model_update();
        logic [2:0] upd;
        logic [2:0] nstable;
        logic [2:0] clr;
        logic       wr;
        if (!reset_n) begin
            model_clear();
            return;
        end
        upd = '0;
        for (int i = 0; i < 3; i++) begin
            bit all;
            all = 1'b1;
            for (int j = 1; j <= D; j++) if (hist[j][i] == m_stable[i]) all = 1'b0;
            upd[i] = all;
        end
        nstable = m_stable ^ upd;
        wr  = chipselect && !write_n;
        clr = (wr && address == 2'd3) ? writedata[2:0] : 3'b000;
        if (wr && address == 2'd2) m_mask = writedata[2:0];
        m_ecap_a = (m_ecap_a & ~clr) | upd;
        m_ecap_r = (m_ecap_r & ~clr) | (upd & nstable);
        m_stable = nstable;
        for (int j = D; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = in_port;
    endtask

    function automatic logic [31:0] exp_rd(input bit rising_dut);
        case (address)
            2'd0:    return {29'd0, m_stable};
            2'd2:    return {29'd0, m_mask};
            2'd3:    return {29'd0, rising_dut ? m_ecap_r : m_ecap_a};
            default: return 32'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_rd_any", bus_a.readdata, exp_rd(1'b0));
            check("cyc_rd_rise", bus_r.readdata, exp_rd(1'b1));
            check("cyc_irq_any", {31'd0, irq_a}, {31'd0, |(m_ecap_a & m_mask)});
            check("cyc_irq_rise", {31'd0, irq_r}, {31'd0, |(m_ecap_r & m_mask)});
        end
    end

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_check(input string name, input logic [1:0] a,
                            input logic [31:0] exp_a, input logic [31:0] exp_r);
        address = a;
        #1;
        check({name, "_any"}, bus_a.readdata, exp_a);
        check({name, "_rise"}, bus_r.readdata, exp_r);
    endtask

    task automatic irq_check(input string name, input logic exp_a, input logic exp_r);
        check({name, "_any"}, {31'd0, irq_a}, {31'd0, exp_a});
        check({name, "_rise"}, {31'd0, irq_r}, {31'd0, exp_r});
    endtask

    initial begin
        model_clear();
        in_port = 3'b111;
        reset_n = 1'b0;
        step();
        cmp_en = 1'b1;
        steps(2);
        rd_check("rst_a0", 2'd0, 0, 0);
        rd_check("rst_a1", 2'd1, 0, 0);
        rd_check("rst_a2", 2'd2, 0, 0);
        rd_check("rst_a3", 2'd3, 0, 0);
        irq_check("rst_irq", 1'b0, 1'b0);

        reset_n = 1'b1;
        steps(5);
        rd_check("init_e5", 2'd0, 0, 0);
        step();
        rd_check("init_e6", 2'd0, 32'h7, 32'h7);
        rd_check("init_cap", 2'd3, 32'h7, 32'h7);
        wr_reg(2'd3, 32'h7);

        in_port = 3'b000;
        steps(D + 3);
        rd_check("fall_cap", 2'd3, 32'h7, 32'h0);
        wr_reg(2'd3, 32'h7);
        in_port = 3'b101;
        steps(5);
        rd_check("lat_n4", 2'd0, 0, 0);
        step();
        rd_check("lat_n5", 2'd0, 32'h5, 32'h5);
        rd_check("lat_cap", 2'd3, 32'h5, 32'h5);

        wr_reg(2'd3, 32'h7);
        in_port = 3'b111;
        steps(3);
        in_port = 3'b101;
        steps(D + 3);
        rd_check("glitch_data", 2'd0, 32'h5, 32'h5);
        rd_check("glitch_cap", 2'd3, 32'h0, 32'h0);

        wr_reg(2'd2, 32'h4);
        in_port = 3'b001;
        steps(5);
        irq_check("irq_pre", 1'b0, 1'b0);
        step();
        irq_check("irq_upd", 1'b1, 1'b0);
        wr_reg(2'd3, 32'h4);
        irq_check("irq_w1c", 1'b0, 1'b0);
        in_port = 3'b011;
        steps(D + 3);
        rd_check("mask_cap", 2'd3, 32'h2, 32'h2);
        irq_check("mask_irq", 1'b0, 1'b0);

        wr_reg(2'd2, 32'h1);
        wr_reg(2'd3, 32'h7);
        in_port = 3'b010;
        steps(5);
        wr_reg(2'd3, 32'h1);
        rd_check("setprio_cap", 2'd3, 32'h1, 32'h0);
        irq_check("setprio_irq", 1'b1, 1'b0);

        in_port = 3'b101;
        steps(3);
        reset_n = 1'b0;
        model_clear();
        rd_check("midrst_data", 2'd0, 0, 0);
        rd_check("midrst_cap", 2'd3, 0, 0);
        irq_check("midrst_irq", 1'b0, 1'b0);
        steps(2);
        reset_n = 1'b1;
        steps(5);
        rd_check("rerel_e5", 2'd3, 0, 0);
        step();
        rd_check("rerel_e6", 2'd3, 32'h5, 32'h5);

        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 5) == 0) in_port = 3'($urandom);
            address    = 2'($urandom);
            writedata  = $urandom;
            chipselect = ($urandom_range(0, 2) == 0);
            write_n    = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 199) == 0) begin
                reset_n = 1'b0;
                model_clear();
            end
            step();
            reset_n = 1'b1;
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        step();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
